// File: rtl/leaf_tag_fifo.sv
// Tagged valid/ready FIFO leaf: stamps each accepted beat with a wrapping sequence tag,
// buffers DEPTH entries and supports drain-and-reset. Optional parity column: LEAF_TAG_FIFO_PARITY_EN.
module leaf_tag_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
`ifdef LEAF_TAG_FIFO_PARITY_EN
  output logic                     out_par,
`endif
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     drain_req,
  output logic                     drain_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_n;
  logic [DATA_W-1:0]   mem_data [DEPTH];
  logic [TAG_W-1:0]    mem_tag  [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr, rd_ptr_n;
  logic [LW-1:0]       level_n;
  logic [TAG_W-1:0]    tag_q;
  logic                push, pop, head_from_in;

  assign in_ready     = !rst && (level < FULL) && (state_q == RUN);
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign level_n      = level + LW'(push) - LW'(pop);
  assign rd_ptr_n     = rd_ptr + PW'(pop);
  // The beat being written becomes the head when nothing older survives this cycle.
  assign head_from_in = push && (level == LW'(pop));

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      RUN:     if (drain_req) state_n = DRAIN;
      DRAIN:   if (level == '0) state_n = DONE;
      DONE:    state_n = RUN;
      default: state_n = RUN;
    endcase
  end

`ifdef LEAF_TAG_FIFO_PARITY_EN
  logic mem_par [DEPTH];
  logic par_in;
  assign par_in = ^{in_data, tag_q};

  always_ff @(posedge clk) begin
    if (push) mem_par[wr_ptr] <= par_in;
  end

  always_ff @(posedge clk) begin
    if (rst)                  out_par <= 1'b0;
    else if (head_from_in)    out_par <= par_in;
    else if (level_n != '0)   out_par <= mem_par[rd_ptr_n];
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_tag[wr_ptr]  <= tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      drain_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      level      <= level_n;
      rd_ptr     <= rd_ptr_n;
      drain_done <= (state_n == DONE);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (state_n == DONE)  tag_q <= '0;
      else if (push)        tag_q <= tag_q + TAG_W'(1);
      out_valid <= (level_n != '0);
      if (head_from_in) begin
        out_data <= in_data;
        out_tag  <= tag_q;
      end else if (level_n != '0) begin
        out_data <= mem_data[rd_ptr_n];
        out_tag  <= mem_tag[rd_ptr_n];
      end
    end
  end

endmodule

// File: doc/leaf_tag_fifo.md
Name: leaf_tag_fifo

Overview:
- Leaf stage instantiated under each sa8_* hierarchy node; gives the otherwise empty module tree real sequential content for regression of elaboration and simulation flows.
- Accepts a valid/ready data stream, stamps each accepted beat with a wrapping sequence tag, buffers it in a DEPTH-entry FIFO and presents it downstream on a valid/ready interface.
- Supports a drain-and-reset request so the parent can quiesce all leaf stages between test phases.

Parameters:
- DATA_W, 8: payload width in bits (>=1).
- DEPTH, 4: FIFO entries; power of two, >=2.
- TAG_W, 4: sequence tag width in bits; tag wraps modulo 2^TAG_W.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head.
- out_data  output  DATA_W  head payload.
- out_tag  output  TAG_W  head sequence tag.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drain_req  input  1  single-cycle request to drain and reset the tag.
- drain_done  output  1  single-cycle pulse when the drain completes.

Behaviour:
- Interface decision: one clock, clk; reset is rst, synchronous and active-high.
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after, level=0, out_valid=0, out_data=0, out_tag=0, drain_done=0, tag counter=0, FSM=RUN. FIFO storage is not reset.
- Accept rule: a beat is accepted when in_valid && in_ready. It is written with tag = tag counter, then the tag counter increments mod 2^TAG_W.
- Pop rule: the head is popped when out_valid && out_ready.
- Latency: out_valid rises the cycle after the first accept into an empty FIFO. There is no same-cycle bypass.
- Outputs are registered from FIFO storage. out_data and out_tag hold stable while out_valid && !out_ready.
- in_ready = (level < DEPTH) && state==RUN. Full with a simultaneous pop does not raise in_ready in that cycle.
- Simultaneous push and pop: allowed when 0 < level < DEPTH; level is unchanged.
- Pointers wrap modulo DEPTH.
- Empty: out_valid=0 and out_ready is ignored.
- FSM state RUN: normal operation. drain_req=1 moves to DRAIN next cycle. An accept in the same cycle as drain_req still completes.
- FSM state DRAIN: in_ready=0 and pops continue normally. When level==0, move to DONE next cycle.
- FSM state DONE: lasts one cycle with drain_done=1 and the tag counter cleared to 0. Then return to RUN.
- drain_req is ignored outside RUN.
- rst in any state, including mid-drain: immediate return to reset values. No drain_done pulse is issued.
- level always equals pushes minus pops since reset and never exceeds DEPTH.

Optional Feature:
- Macro: LEAF_TAG_FIFO_PARITY_EN.
- When defined: adds output port out_par (1 bit) = even parity (XOR reduction) of {in_data, tag}, computed at write time, stored per entry and presented with the head. It is 0 in reset.
- When undefined: the port and the storage column are absent; all other behaviour is identical.

Test Plan:
- Basic flow: DEPTH=4, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 with out_tag 0,1,2, each one cycle after its accept.
- Full backpressure: out_ready=0, push 5 beats -> in_ready=0 after the 4th, level=4, 5th not accepted. Raise out_ready -> order preserved, in_ready returns the cycle after the first pop.
- Tag wrap: TAG_W=4, stream 18 beats -> tags 0..15,0,1. Fill/drain 3x -> pointer wrap with no data corruption.
- Drain: level=3, pulse drain_req -> in_ready=0 while 3 beats pop, drain_done one cycle after level hits 0, next accepted beat carries tag 0.
- Reset mid-drain: assert rst during DRAIN with level=2 -> next cycle level=0, out_valid=0, no drain_done. Then normal accept resumes with tag 0.
- Parity (with LEAF_TAG_FIFO_PARITY_EN): data 0x03 tag 0 -> out_par=0; data 0x01 tag 1 -> out_par=0; data 0x07 tag 0 -> out_par=1.
